// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_pkg.sv
// Shared state encoding and default widths for the 62x64 1R1W array BIST fail-log encoder.
package arf062b064e1r1w0cbbehsaa4acw_bist_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } bist_state_e;

  localparam int DEF_IN_WIDTH   = 64;
  localparam int DEF_OUT_WIDTH  = 6;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_prio_encoder.sv
// LSB-first priority encoder; also flags a vector with exactly one bit set.
module arf062b064e1r1w0cbbehsaa4acw_bist_prio_encoder
  import arf062b064e1r1w0cbbehsaa4acw_bist_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  vec,
  output logic [OUT_WIDTH-1:0] idx,
  output logic                 onehot_only
);

  localparam logic [IN_WIDTH-1:0] ONE = IN_WIDTH'(1);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = OUT_WIDTH'(i);
    end
  end

  assign onehot_only = (vec != '0) && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/arf062b064e1r1w0cbbehsaa4acw_bist_fail_encoder.sv
// Serialises a multi-hot compare-fail vector into one bit-index beat per cycle.
// Beat counter is built only when ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CNT_EN is defined.
module arf062b064e1r1w0cbbehsaa4acw_bist_fail_encoder
  import arf062b064e1r1w0cbbehsaa4acw_bist_pkg::*;
#(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  fail_vld,
  output logic                  fail_rdy,
  input  logic [IN_WIDTH-1:0]   fail_vec,
  input  logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  log_vld,
  input  logic                  log_rdy,
  output logic [OUT_WIDTH-1:0]  log_bit,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic                  log_last,
  input  logic                  bist_clr,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic                  fail_cnt_sat
);

  localparam logic [0:0]          ST_IDLE = IDLE;
  localparam logic [0:0]          ST_SCAN = SCAN;
  localparam logic [IN_WIDTH-1:0] ONE     = IN_WIDTH'(1);

  logic [0:0]            state;
  logic [IN_WIDTH-1:0]   pending;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [OUT_WIDTH-1:0]  low_idx;
  logic                  low_only;
  logic                  beat;

  arf062b064e1r1w0cbbehsaa4acw_bist_prio_encoder #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_prio (
    .vec         (pending),
    .idx         (low_idx),
    .onehot_only (low_only)
  );

  // Outputs decode straight from flops; pending is zero in IDLE so log_bit/log_last rest at 0.
  assign fail_rdy = (state == ST_IDLE);
  assign log_vld  = (state == ST_SCAN);
  assign log_bit  = low_idx;
  assign log_last = low_only;
  assign log_addr = addr_q;
  assign beat     = log_vld && log_rdy;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state   <= ST_IDLE;
      pending <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fail_vld && (fail_vec != '0)) begin
            pending <= fail_vec;
            addr_q  <= fail_addr;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Subtract-and-mask drops exactly the lowest set bit, i.e. the one just logged.
          if (beat) begin
            pending <= pending & (pending - ONE);
            if (low_only) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARF062B064E1R1W0CBBEHSAA4ACW_BIST_FAIL_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 sat_q;

  // Clear has priority over a coincident beat.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (bist_clr) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (beat && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_ONE;
      if ((cnt_q + CNT_ONE) == '1) sat_q <= 1'b1;
    end
  end

  assign fail_cnt     = cnt_q;
  assign fail_cnt_sat = sat_q;
`else
  logic unused_clr;

  assign unused_clr   = bist_clr;
  assign fail_cnt     = '0;
  assign fail_cnt_sat = 1'b0;
`endif

endmodule
